// File: rtl/lid_reg_multi.sv
// Latency-insensitive register with NREAD independent readers and a DEPTH-entry pending-write
// queue. Define LID_REG_MULTI_OCC_EN to expose the queue occupancy on OCC and check its bound.
module lid_reg_multi #(
  parameter int unsigned      WIDTH = 1,
  parameter logic [WIDTH-1:0] INIT  = '0,
  parameter int unsigned      DEPTH = 2,
  parameter int unsigned      NREAD = 1
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic [WIDTH-1:0]             IN_WRITE,
  input  logic                         IN_WRITE_VALID,
  output logic                         IN_WRITE_CONSUMED,
  input  logic                         IN_EN_WRITE,
  input  logic                         IN_EN_WRITE_VALID,
  output logic                         IN_EN_WRITE_CONSUMED,
  output logic [WIDTH-1:0]             OUT_READ,
  output logic [NREAD-1:0]             OUT_READ_VALID,
`ifdef LID_REG_MULTI_OCC_EN
  output logic [$clog2(DEPTH+1)-1:0]   OCC,
`endif
  input  logic [NREAD-1:0]             OUT_READ_CONSUMED
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic             r_cur_v;
  logic [WIDTH-1:0] r_cur_d;
  logic [WIDTH-1:0] r_q_data [DEPTH];
  logic [DEPTH-1:0] r_q_en;
  logic [PW-1:0]    r_head, r_tail;
  logic [CW-1:0]    r_count;
  logic [NREAD-1:0] r_done;

  logic             w_in_v, w_full, w_enq;
  logic [NREAD-1:0] w_take;
  logic             w_retire, w_refill, w_pop, w_push, w_bypass;
  logic [PW-1:0]    w_head_nxt, w_tail_nxt;

  // Input acceptance depends only on registered count, never on reader handshakes.
  always_comb begin
    w_in_v     = IN_WRITE_VALID & IN_EN_WRITE_VALID;
    w_full     = (r_count == CW'(DEPTH));
    w_enq      = w_in_v & ~w_full;
    w_take     = OUT_READ_VALID & OUT_READ_CONSUMED;
    w_retire   = r_cur_v & (&(r_done | w_take));
    w_refill   = w_retire | ~r_cur_v;
    w_pop      = w_refill & (r_count != '0);
    w_bypass   = w_refill & (r_count == '0) & w_enq;
    w_push     = w_enq & ~w_bypass;
    w_head_nxt = (r_head == PW'(DEPTH - 1)) ? '0 : r_head + PW'(1);
    w_tail_nxt = (r_tail == PW'(DEPTH - 1)) ? '0 : r_tail + PW'(1);
  end

  assign IN_WRITE_CONSUMED    = w_in_v ? ~w_full : 1'b1;
  assign IN_EN_WRITE_CONSUMED = w_in_v ? ~w_full : 1'b1;
  assign OUT_READ             = r_cur_d;
  assign OUT_READ_VALID       = {NREAD{r_cur_v}} & ~r_done;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_cur_v <= 1'b1;
      r_cur_d <= INIT;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_done  <= '0;
    end else begin
      r_done <= w_retire ? '0 : (r_done | w_take);
      if (w_pop) begin
        r_cur_v <= 1'b1;
        if (r_q_en[r_head]) r_cur_d <= r_q_data[r_head];
        r_head <= w_head_nxt;
      end else if (w_bypass) begin
        r_cur_v <= 1'b1;
        if (IN_EN_WRITE) r_cur_d <= IN_WRITE;
      end else if (w_refill) begin
        r_cur_v <= 1'b0;
      end
      if (w_push) r_tail <= w_tail_nxt;
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

  // Queue storage needs no reset: entries are only read while counted.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_q_data[r_tail] <= IN_WRITE;
      r_q_en[r_tail]   <= IN_EN_WRITE;
    end
  end

`ifdef LID_REG_MULTI_OCC_EN
  assign OCC = r_count;
`ifndef SYNTHESIS
  a_count_bound: assert property (@(posedge CLK) disable iff (!RST_N) r_count <= CW'(DEPTH));
`endif
`endif

endmodule

// File: tb/tb_lid_reg_multi.sv
// Directed bench for lid_reg_multi (WIDTH=8, INIT=5A, DEPTH=3, NREAD=2) with a token-level
// scoreboard: accepted writes push expected read values, full retirement pops them.
module tb_lid_reg_multi;

  localparam int unsigned WIDTH = 8;
  localparam logic [7:0]  INIT  = 8'h5A;
  localparam int          DEPTH = 3;
  localparam int unsigned NREAD = 2;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [7:0] IN_WRITE = '0;
  logic       IN_WRITE_VALID = 1'b0;
  logic       IN_WRITE_CONSUMED;
  logic       IN_EN_WRITE = 1'b0;
  logic       IN_EN_WRITE_VALID = 1'b0;
  logic       IN_EN_WRITE_CONSUMED;
  logic [7:0] OUT_READ;
  logic [1:0] OUT_READ_VALID;
  logic [1:0] OUT_READ_CONSUMED = '0;
`ifdef LID_REG_MULTI_OCC_EN
  logic [$clog2(DEPTH+1)-1:0] OCC;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] m_val;
  logic [1:0] m_done;

  always #5 CLK = ~CLK;

  lid_reg_multi #(
    .WIDTH(WIDTH),
    .INIT (INIT),
    .DEPTH(DEPTH),
    .NREAD(NREAD)
  ) dut (
    .CLK                 (CLK),
    .RST_N               (RST_N),
    .IN_WRITE            (IN_WRITE),
    .IN_WRITE_VALID      (IN_WRITE_VALID),
    .IN_WRITE_CONSUMED   (IN_WRITE_CONSUMED),
    .IN_EN_WRITE         (IN_EN_WRITE),
    .IN_EN_WRITE_VALID   (IN_EN_WRITE_VALID),
    .IN_EN_WRITE_CONSUMED(IN_EN_WRITE_CONSUMED),
    .OUT_READ            (OUT_READ),
    .OUT_READ_VALID      (OUT_READ_VALID),
`ifdef LID_REG_MULTI_OCC_EN
    .OCC                 (OCC),
`endif
    .OUT_READ_CONSUMED   (OUT_READ_CONSUMED)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    IN_WRITE_VALID = 1'b0;
    IN_EN_WRITE_VALID = 1'b0;
    OUT_READ_CONSUMED = '0;
    @(negedge CLK);
    RST_N = 1'b1;
    exp_q.delete();
    exp_q.push_back(INIT);
    m_val  = INIT;
    m_done = '0;
  endtask

  // One cycle: drive at negedge, check outputs 1 time unit later, advance the model.
  task automatic step(input logic wv, input logic [7:0] wd, input logic en,
                      input logic [1:0] rc);
    logic       exp_cons;
    logic [1:0] exp_valid;
    logic [1:0] take;
    @(negedge CLK);
    IN_WRITE_VALID    = wv;
    IN_EN_WRITE_VALID = wv;
    IN_WRITE          = wd;
    IN_EN_WRITE       = en;
    OUT_READ_CONSUMED = rc;
    #1;
    exp_cons  = !(wv && (exp_q.size() == DEPTH + 1));
    exp_valid = (exp_q.size() > 0) ? ~m_done : 2'b00;
    check("write_consumed", 32'(IN_WRITE_CONSUMED), 32'(exp_cons));
    check("en_consumed", 32'(IN_EN_WRITE_CONSUMED), 32'(exp_cons));
    check("read_valid", 32'(OUT_READ_VALID), 32'(exp_valid));
    if (exp_q.size() > 0) check("read_data", 32'(OUT_READ), 32'(exp_q[0]));
`ifdef LID_REG_MULTI_OCC_EN
    check("occ", 32'(OCC), (exp_q.size() > 0) ? 32'(exp_q.size() - 1) : 32'd0);
`endif
    take = exp_valid & rc;
    if (exp_q.size() > 0 && (&(m_done | take))) begin
      void'(exp_q.pop_front());
      m_done = '0;
    end else begin
      m_done = m_done | take;
    end
    if (wv && exp_cons) begin
      if (en) m_val = wd;
      exp_q.push_back(m_val);
    end
  endtask

  initial begin
    do_reset();

    // Reset state, directly against constants
    #1;
    check("reset_read", 32'(OUT_READ), 32'h5A);
    check("reset_valid", 32'(OUT_READ_VALID), 32'h3);
    check("reset_wcons", 32'(IN_WRITE_CONSUMED), 32'h1);
    check("reset_econs", 32'(IN_EN_WRITE_CONSUMED), 32'h1);
    step(1'b0, 8'h00, 1'b0, 2'b00);

    // Staggered readers retire INIT; register then empties
    step(1'b0, 8'h00, 1'b0, 2'b01);
    step(1'b0, 8'h00, 1'b0, 2'b10);
    step(1'b0, 8'h00, 1'b0, 2'b00);
    check("empty_valid", 32'(OUT_READ_VALID), 32'h0);

    // Enable token: 11 en=1 then 22 en=0 both read as 11
    step(1'b1, 8'h11, 1'b1, 2'b00);
    step(1'b0, 8'h00, 1'b0, 2'b11);
    step(1'b1, 8'h22, 1'b0, 2'b00);
    check("held_value", 32'(OUT_READ), 32'h11);
    step(1'b0, 8'h00, 1'b0, 2'b11);
    step(1'b0, 8'h00, 1'b0, 2'b00);

    // Full queue: stalled readers, five writes; fifth refused, even across a retire
    step(1'b1, 8'hA1, 1'b1, 2'b00);
    step(1'b1, 8'hA2, 1'b1, 2'b00);
    step(1'b1, 8'hA3, 1'b1, 2'b00);
    step(1'b1, 8'hA4, 1'b1, 2'b00);
    step(1'b1, 8'hA5, 1'b1, 2'b00);
    check("full_refuse", 32'(IN_WRITE_CONSUMED), 32'h0);
    step(1'b1, 8'hA5, 1'b1, 2'b01);
    step(1'b1, 8'hA5, 1'b1, 2'b10);
    // Count now 2: simultaneous enqueue and retire keeps count and order
    step(1'b1, 8'hA5, 1'b1, 2'b11);
    step(1'b0, 8'h00, 1'b0, 2'b11);
    step(1'b0, 8'h00, 1'b0, 2'b10);
    step(1'b0, 8'h00, 1'b0, 2'b01);
    step(1'b0, 8'h00, 1'b0, 2'b11);
    step(1'b0, 8'h00, 1'b0, 2'b00);

    // Fill to count 3, then reset mid-operation
    step(1'b1, 8'hC1, 1'b1, 2'b00);
    step(1'b1, 8'hC2, 1'b0, 2'b00);
    step(1'b1, 8'hC3, 1'b1, 2'b00);
    step(1'b1, 8'hC4, 1'b1, 2'b00);
    do_reset();
    #1;
    check("rst2_read", 32'(OUT_READ), 32'h5A);
    check("rst2_valid", 32'(OUT_READ_VALID), 32'h3);
`ifdef LID_REG_MULTI_OCC_EN
    check("rst2_occ", 32'(OCC), 32'h0);
`endif
    step(1'b0, 8'h00, 1'b0, 2'b11);
    step(1'b1, 8'hD7, 1'b1, 2'b00);
    step(1'b0, 8'h00, 1'b0, 2'b11);
    step(1'b0, 8'h00, 1'b0, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
